// File: rtl/keypad_pkg.sv
// Shared types, widths, parameter defaults and small bit helpers for the keypad decoder.
package keypad_pkg;

    localparam int KEY_W              = 4;
    localparam int ROW_W              = 2;
    localparam int DEBOUNCE_SCANS_DEF = 2;
    localparam int REPEAT_SCANS_DEF   = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } key_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_res_t;

    function automatic logic [2:0] popcount4(input logic [3:0] m);
        return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction

    // Index of the lowest set bit; only meaningful when exactly one bit is set.
    function automatic logic [1:0] low_index4(input logic [3:0] m);
        logic [1:0] idx;
        if (m[0]) begin
            idx = 2'd0;
        end else if (m[1]) begin
            idx = 2'd1;
        end else if (m[2]) begin
            idx = 2'd2;
        end else if (m[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad scan bus: row index and raw columns in, decoded key information out.
interface keypad_if;
    import keypad_pkg::*;

    logic [ROW_W-1:0] ROW_IDX;
    logic [3:0]       COL_IN;
    logic [KEY_W-1:0] KEY_CODE;
    logic             KEY_VALID;
    logic             KEY_HELD;
    logic             MULTI_KEY;

    modport master (
        output ROW_IDX, COL_IN,
        input  KEY_CODE, KEY_VALID, KEY_HELD, MULTI_KEY
    );

    modport slave (
        input  ROW_IDX, COL_IN,
        output KEY_CODE, KEY_VALID, KEY_HELD, MULTI_KEY
    );
endinterface

// File: rtl/keypad_col_sync.sv
// Two-flop column synchronizer plus a matching two-flop row delay, so every
// synchronized column sample leaves paired with the row that produced it.
module keypad_col_sync
    import keypad_pkg::*;
(
    input  logic             CLK_100HZ,
    input  logic             RESET_N,
    input  logic [3:0]       col_in,
    input  logic [ROW_W-1:0] row_idx,
    output logic [3:0]       col_sync,
    output logic [ROW_W-1:0] row_sync
);

    logic [3:0]       col_meta_r;
    logic [3:0]       col_sync_r;
    logic [ROW_W-1:0] row_d1_r;
    logic [ROW_W-1:0] row_d2_r;

    // Column synchronizer and row delay line; columns idle high.
    always_ff @(posedge CLK_100HZ or negedge RESET_N) begin
        if (!RESET_N) begin
            col_meta_r <= 4'b1111;
            col_sync_r <= 4'b1111;
            row_d1_r   <= {ROW_W{1'b0}};
            row_d2_r   <= {ROW_W{1'b0}};
        end else begin
            col_meta_r <= col_in;
            col_sync_r <= col_meta_r;
            row_d1_r   <= row_idx;
            row_d2_r   <= row_d1_r;
        end
    end

    assign col_sync = col_sync_r;
    assign row_sync = row_d2_r;

endmodule

// File: rtl/keypad_decoder.sv
// Keypad frame accumulator and debounce FSM producing key code, valid pulse,
// held and multi-key flags. Optional auto-repeat enabled by KEYPAD_REPEAT_EN.
module keypad_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF,
    parameter int REPEAT_SCANS   = REPEAT_SCANS_DEF
) (
    input  logic    CLK_100HZ,
    input  logic    RESET_N,
    keypad_if.slave kp
);

    localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_SCANS);

    logic [3:0]       col_sync_s;
    logic [ROW_W-1:0] row_sync_s;
    logic [3:0]       hit_mask_s;
    logic [2:0]       sample_hits_s;
    logic [2:0]       frame_hits_s;
    logic [KEY_W-1:0] sample_code_s;
    logic [KEY_W-1:0] frame_code_s;
    frame_res_t       frame_res_s;
    logic             frame_close_s;

    logic [1:0]       acc_hits_r;
    logic [1:0]       acc_hits_next_s;
    logic [KEY_W-1:0] acc_code_r;
    logic [KEY_W-1:0] acc_code_next_s;

    key_state_t       state_r;
    key_state_t       state_next_s;
    logic [KEY_W-1:0] cand_r;
    logic [KEY_W-1:0] cand_next_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_next_s;
    logic [3:0]       cnt_inc_s;
    logic [KEY_W-1:0] code_r;
    logic [KEY_W-1:0] code_next_s;
    logic             accept_s;
    logic             valid_next_s;
    logic             multi_next_s;
    logic             valid_r;
    logic             held_r;
    logic             multi_r;

    keypad_col_sync u_col_sync (
        .CLK_100HZ (CLK_100HZ),
        .RESET_N   (RESET_N),
        .col_in    (kp.COL_IN),
        .row_idx   (kp.ROW_IDX),
        .col_sync  (col_sync_s),
        .row_sync  (row_sync_s)
    );

    assign hit_mask_s    = ~col_sync_s;
    assign sample_hits_s = popcount4(hit_mask_s);
    assign sample_code_s = {row_sync_s, low_index4(hit_mask_s)};
    assign frame_close_s = (row_sync_s == 2'd3);
    assign cnt_inc_s     = (cnt_r == 4'hF) ? cnt_r : cnt_r + 4'd1;

    // Frame result including the closing sample, and the accumulator update.
    always_comb begin
        frame_hits_s = {1'b0, acc_hits_r} + sample_hits_s;
        frame_code_s = (acc_hits_r == 2'd0) ? sample_code_s : acc_code_r;
        if (frame_hits_s == 3'd0) begin
            frame_res_s = NONE;
        end else if (frame_hits_s == 3'd1) begin
            frame_res_s = SINGLE;
        end else begin
            frame_res_s = MULTI;
        end
        if (frame_close_s) begin
            acc_hits_next_s = 2'd0;
            acc_code_next_s = {KEY_W{1'b0}};
        end else begin
            // Two means "two or more", which is all the frame result needs.
            acc_hits_next_s = (frame_hits_s >= 3'd2) ? 2'd2 : frame_hits_s[1:0];
            acc_code_next_s = frame_code_s;
        end
    end

    // Debounce FSM next-state logic, evaluated only at frame close.
    always_comb begin
        state_next_s = state_r;
        cand_next_s  = cand_r;
        cnt_next_s   = cnt_r;
        code_next_s  = code_r;
        accept_s     = 1'b0;
        multi_next_s = multi_r;
        if (frame_close_s) begin
            multi_next_s = (frame_res_s == MULTI);
            case (state_r)
                IDLE: begin
                    if (frame_res_s == SINGLE) begin
                        cand_next_s = frame_code_s;
                        cnt_next_s  = 4'd1;
                        if (DEB_LIMIT <= 4'd1) begin
                            state_next_s = PRESSED;
                            code_next_s  = frame_code_s;
                            accept_s     = 1'b1;
                        end else begin
                            state_next_s = DEBOUNCE;
                        end
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                DEBOUNCE: begin
                    if ((frame_res_s == SINGLE) && (frame_code_s == cand_r)) begin
                        cnt_next_s = cnt_inc_s;
                        if (cnt_inc_s >= DEB_LIMIT) begin
                            state_next_s = PRESSED;
                            code_next_s  = cand_r;
                            accept_s     = 1'b1;
                        end else begin
                            state_next_s = DEBOUNCE;
                        end
                    end else begin
                        state_next_s = IDLE;
                        cnt_next_s   = 4'd0;
                    end
                end
                PRESSED: begin
                    if (frame_res_s == NONE) begin
                        if (DEB_LIMIT <= 4'd1) begin
                            state_next_s = IDLE;
                            cnt_next_s   = 4'd0;
                        end else begin
                            state_next_s = RELEASE;
                            cnt_next_s   = 4'd1;
                        end
                    end else begin
                        state_next_s = PRESSED;
                    end
                end
                RELEASE: begin
                    if (frame_res_s == NONE) begin
                        if (cnt_inc_s >= DEB_LIMIT) begin
                            state_next_s = IDLE;
                            cnt_next_s   = 4'd0;
                        end else begin
                            state_next_s = RELEASE;
                            cnt_next_s   = cnt_inc_s;
                        end
                    end else begin
                        state_next_s = PRESSED;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    cnt_next_s   = 4'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] REP_LIMIT = 8'(REPEAT_SCANS);

    logic [7:0] rep_r;
    logic [7:0] rep_next_s;
    logic [7:0] rep_inc_s;
    logic       rep_pulse_s;

    assign rep_inc_s = (rep_r == 8'hFF) ? rep_r : rep_r + 8'd1;

    // Repeat counter: restarts on a fresh acceptance, runs in PRESSED, frozen in RELEASE.
    always_comb begin
        rep_next_s  = rep_r;
        rep_pulse_s = 1'b0;
        if (frame_close_s && (state_next_s == PRESSED)) begin
            if ((state_r == IDLE) || (state_r == DEBOUNCE)) begin
                rep_next_s = 8'd0;
            end else if (state_r == PRESSED) begin
                if (rep_inc_s >= REP_LIMIT) begin
                    rep_next_s  = 8'd0;
                    rep_pulse_s = 1'b1;
                end else begin
                    rep_next_s = rep_inc_s;
                end
            end else begin
                rep_next_s = rep_r;
            end
        end else begin
            rep_next_s = rep_r;
        end
    end

    // Repeat counter register.
    always_ff @(posedge CLK_100HZ or negedge RESET_N) begin
        if (!RESET_N) begin
            rep_r <= 8'd0;
        end else begin
            rep_r <= rep_next_s;
        end
    end

    assign valid_next_s = accept_s | rep_pulse_s;
`else
    logic [7:0] rep_param_unused_s;
    assign rep_param_unused_s = 8'(REPEAT_SCANS);
    assign valid_next_s       = accept_s;
`endif

    // State, frame accumulator and registered outputs.
    always_ff @(posedge CLK_100HZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r    <= IDLE;
            cand_r     <= {KEY_W{1'b0}};
            cnt_r      <= 4'd0;
            code_r     <= {KEY_W{1'b0}};
            valid_r    <= 1'b0;
            held_r     <= 1'b0;
            multi_r    <= 1'b0;
            acc_hits_r <= 2'd0;
            acc_code_r <= {KEY_W{1'b0}};
        end else begin
            state_r    <= state_next_s;
            cand_r     <= cand_next_s;
            cnt_r      <= cnt_next_s;
            code_r     <= code_next_s;
            valid_r    <= valid_next_s;
            held_r     <= (state_next_s == PRESSED) || (state_next_s == RELEASE);
            multi_r    <= multi_next_s;
            acc_hits_r <= acc_hits_next_s;
            acc_code_r <= acc_code_next_s;
        end
    end

    assign kp.KEY_CODE  = code_r;
    assign kp.KEY_VALID = valid_r;
    assign kp.KEY_HELD  = held_r;
    assign kp.MULTI_KEY = multi_r;

endmodule

// File: tb/tb_keypad_decoder.sv
// Scoreboard bench for keypad_decoder: frames are driven row by row, expected
// key pulses are queued per frame and a forked monitor pops them on KEY_VALID.
module tb_keypad_decoder;
    import keypad_pkg::*;

    localparam int DEB = 2;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP    = 3;
    localparam bit REP_ON = 1'b1;
`else
    localparam int REP    = 10;
    localparam bit REP_ON = 1'b0;
`endif

    logic CLK_100HZ = 1'b0;
    logic RESET_N   = 1'b0;

    keypad_if kif ();

    keypad_decoder #(
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (REP)
    ) dut (
        .CLK_100HZ (CLK_100HZ),
        .RESET_N   (RESET_N),
        .kp        (kif)
    );

    always #5 CLK_100HZ = ~CLK_100HZ;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    logic       pend_chk   = 1'b0;
    logic       pend_held  = 1'b0;
    logic       pend_multi = 1'b0;
    string      pend_name  = "";

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] key_bit(input int k);
        logic [15:0] one;
        one = 16'd1;
        return one << k;
    endfunction

    task automatic drive_row(input int r, input logic [15:0] mask);
        kif.ROW_IDX = 2'(r);
        kif.COL_IN  = ~mask[r*4 +: 4];
    endtask

    task automatic check_pending();
        if (pend_chk) begin
            check({pend_name, "_held"},  {3'b000, kif.KEY_HELD},  {3'b000, pend_held});
            check({pend_name, "_multi"}, {3'b000, kif.MULTI_KEY}, {3'b000, pend_multi});
        end
    endtask

    // One full frame; levels of the previous frame are checked after its close edge.
    task automatic run_frame(input string name, input logic [15:0] mask,
                             input logic exp_held, input logic exp_multi,
                             input logic exp_pulse, input logic [3:0] exp_code);
        for (int r = 0; r < 4; r++) begin
            @(negedge CLK_100HZ);
            if (r == 2) check_pending();
            drive_row(r, mask);
        end
        if (exp_pulse) exp_q.push_back(exp_code);
        pend_chk   = 1'b1;
        pend_name  = name;
        pend_held  = exp_held;
        pend_multi = exp_multi;
    endtask

    task automatic check_outputs_clear(input string name);
        check({name, "_code"},  kif.KEY_CODE, 4'd0);
        check({name, "_valid"}, {3'b000, kif.KEY_VALID}, 4'd0);
        check({name, "_held"},  {3'b000, kif.KEY_HELD},  4'd0);
        check({name, "_multi"}, {3'b000, kif.MULTI_KEY}, 4'd0);
    endtask

    initial begin
        kif.ROW_IDX = 2'd0;
        kif.COL_IN  = 4'b1111;
        fork
            forever begin
                @(negedge CLK_100HZ);
                if (kif.KEY_VALID === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL key_valid: unexpected pulse with KEY_CODE=%0d, expected no pulse",
                                 kif.KEY_CODE);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("pulse_code", kif.KEY_CODE, mon_exp);
                    end
                end
            end
        join_none

        repeat (3) @(negedge CLK_100HZ);
        check_outputs_clear("reset");
        @(negedge CLK_100HZ);
        RESET_N = 1'b1;

        // Steady press of row 1 / col 2.
        run_frame("p6_f1",  key_bit(6), 1'b0, 1'b0, 1'b0, 4'd0);
        run_frame("p6_f2",  key_bit(6), 1'b1, 1'b0, 1'b1, 4'd6);
        run_frame("p6_r1",  16'h0000,   1'b1, 1'b0, 1'b0, 4'd0);
        run_frame("p6_r2",  16'h0000,   1'b0, 1'b0, 1'b0, 4'd0);

        // Bounce present/absent/present, then a second consecutive present frame.
        run_frame("b6_f1",  key_bit(6), 1'b0, 1'b0, 1'b0, 4'd0);
        run_frame("b6_f2",  16'h0000,   1'b0, 1'b0, 1'b0, 4'd0);
        run_frame("b6_f3",  key_bit(6), 1'b0, 1'b0, 1'b0, 4'd0);
        run_frame("b6_f4",  key_bit(6), 1'b1, 1'b0, 1'b1, 4'd6);
        run_frame("b6_r1",  16'h0000,   1'b1, 1'b0, 1'b0, 4'd0);
        run_frame("b6_r2",  16'h0000,   1'b0, 1'b0, 1'b0, 4'd0);

        // Two keys from idle: flagged as multi, never accepted.
        run_frame("m05_f1", key_bit(0) | key_bit(5), 1'b0, 1'b1, 1'b0, 4'd0);
        run_frame("m05_f2", key_bit(0) | key_bit(5), 1'b0, 1'b1, 1'b0, 4'd0);
        run_frame("m05_r",  16'h0000,                1'b0, 1'b0, 1'b0, 4'd0);

        // Second key joins while key 0 is held.
        run_frame("k0_f1",  key_bit(0),              1'b0, 1'b0, 1'b0, 4'd0);
        run_frame("k0_f2",  key_bit(0),              1'b1, 1'b0, 1'b1, 4'd0);
        run_frame("k0_m",   key_bit(0) | key_bit(5), 1'b1, 1'b1, 1'b0, 4'd0);
        run_frame("k0_f3",  key_bit(0),              1'b1, 1'b0, 1'b0, 4'd0);
        run_frame("k0_r1",  16'h0000,                1'b1, 1'b0, 1'b0, 4'd0);
        run_frame("k0_r2",  16'h0000,                1'b0, 1'b0, 1'b0, 4'd0);

        // Short release glitch, then a full release and a fresh press.
        run_frame("k9_f1",  key_bit(9), 1'b0, 1'b0, 1'b0, 4'd0);
        run_frame("k9_f2",  key_bit(9), 1'b1, 1'b0, 1'b1, 4'd9);
        run_frame("k9_g",   16'h0000,   1'b1, 1'b0, 1'b0, 4'd0);
        run_frame("k9_back", key_bit(9), 1'b1, 1'b0, 1'b0, 4'd0);
        run_frame("k9_r1",  16'h0000,   1'b1, 1'b0, 1'b0, 4'd0);
        run_frame("k9_r2",  16'h0000,   1'b0, 1'b0, 1'b0, 4'd0);
        run_frame("k9_n1",  key_bit(9), 1'b0, 1'b0, 1'b0, 4'd0);
        run_frame("k9_n2",  key_bit(9), 1'b1, 1'b0, 1'b1, 4'd9);
        run_frame("k9_n_r1", 16'h0000,  1'b1, 1'b0, 1'b0, 4'd0);
        run_frame("k9_n_r2", 16'h0000,  1'b0, 1'b0, 1'b0, 4'd0);

        // Reset in the middle of a frame while key 3 is debouncing.
        run_frame("k3_pre", key_bit(3), 1'b0, 1'b0, 1'b0, 4'd0);
        for (int r = 0; r < 3; r++) begin
            @(negedge CLK_100HZ);
            if (r == 2) check_pending();
            drive_row(r, key_bit(3));
        end
        @(negedge CLK_100HZ);
        pend_chk = 1'b0;
        RESET_N  = 1'b0;
        #1;
        check_outputs_clear("mid_reset");
        kif.ROW_IDX = 2'd0;
        kif.COL_IN  = 4'b1111;
        repeat (2) @(negedge CLK_100HZ);
        RESET_N = 1'b1;
        run_frame("k3_f1",  key_bit(3), 1'b0, 1'b0, 1'b0, 4'd0);
        run_frame("k3_f2",  key_bit(3), 1'b1, 1'b0, 1'b1, 4'd3);
        run_frame("k3_r1",  16'h0000,   1'b1, 1'b0, 1'b0, 4'd0);
        run_frame("k3_r2",  16'h0000,   1'b0, 1'b0, 1'b0, 4'd0);

        // Corner key held for 10 frames after acceptance.
        run_frame("k15_f1", key_bit(15), 1'b0, 1'b0, 1'b0, 4'd0);
        run_frame("k15_f2", key_bit(15), 1'b1, 1'b0, 1'b1, 4'd15);
        for (int i = 1; i <= 10; i++) begin
            run_frame("k15_hold", key_bit(15), 1'b1, 1'b0, REP_ON && ((i % 3) == 0), 4'd15);
        end
        run_frame("k15_r1", 16'h0000,   1'b1, 1'b0, 1'b0, 4'd0);
        run_frame("k15_r2", 16'h0000,   1'b0, 1'b0, 1'b0, 4'd0);
        run_frame("flush",  16'h0000,   1'b0, 1'b0, 1'b0, 4'd0);
        repeat (4) @(negedge CLK_100HZ);

        check("pulses_outstanding", 4'(exp_q.size()), 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
